// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU opcodes,
// FSM state encoding and the divide-by-zero screen.
package alu_share_ctrl_pkg;

  // ALU opcodes (4-bit f field of the external ALU)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MOD  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NAND = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_XNOR = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;
  localparam logic [3:0] OP_LNOT = 4'd15;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Only mod and div are screened; every other opcode goes to the ALU as-is.
  function automatic logic is_div_zero(input logic [3:0] op, input logic [31:0] b);
    return ((op == OP_MOD) || (op == OP_DIV)) && (b == 32'd0);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester
// strictly after the pointer, wrapping around. Returns one-hot grant,
// the binary index of the grantee and an any-grant flag.
module alu_share_ctrl_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int best_d;
  int d;

  // Rotating priority: the smallest distance past the pointer wins.
  always_comb begin
    best_d = NREQ;
    d      = 0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      d = (j - int'(ptr_i) - 1 + 2 * NREQ) % NREQ;
      if (valid_i[j] && (d < best_d)) begin
        best_d = d;
        idx_o  = IDW'(j);
        any_o  = 1'b1;
      end
    end
  end

  // Expand the winning index to a one-hot grant vector.
  always_comb begin
    grant_o = '0;
    for (int j = 0; j < NREQ; j++) begin
      grant_o[j] = any_o && (idx_o == IDW'(j));
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU among NREQ requesters.
// Flow: IDLE grants a requester round-robin and registers its operands,
// EXEC holds them on the ALU for SETTLE cycles and samples y, RESP holds
// the tagged result until the consumer takes it. Div/mod by zero skips
// EXEC and answers with rsp_dz=1 and a zero result.
// Handshake rules: a request moves on the edge where req_valid[i] and
// req_ready[i] are both 1 (req_ready is one-hot, only in IDLE); the
// response moves on the edge where rsp_valid and rsp_ready are both 1,
// counted from the first edge after rsp_valid rises.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int SETTLE = 2,
  parameter int IDW    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [3:0]        alu_f,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [63:0]       alu_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [63:0]       rsp_y,
  output logic              rsp_dz,
  output logic              busy
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [3:0]      f_q, f_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rv_q, rv_d;
  logic [63:0]     ry_q, ry_d;
  logic            rdz_q, rdz_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [3:0]      sel_op;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  alu_share_ctrl_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  // Route the grantee's opcode and operands to the capture registers.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  // FSM next state plus operand, counter and response register updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    f_d     = f_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    ry_d    = ry_q;
    rdz_d   = rdz_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ptr_d = gnt_idx;
          id_d  = gnt_idx;
          if (is_div_zero(sel_op, sel_b)) begin
            // ALU inputs are left untouched; answer straight away.
            rv_d    = 1'b1;
            rdz_d   = 1'b1;
            ry_d    = '0;
            state_d = ST_RESP;
          end else begin
            f_d     = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            cnt_d   = CW'(1);
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == CW'(SETTLE)) begin
          ry_d    = alu_y;
          rdz_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      ry_q    <= '0;
      rdz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      f_q     <= f_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      ry_q    <= ry_d;
      rdz_q   <= rdz_d;
    end
  end

  // Grants are offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && rst_n) begin
      req_ready = gnt;
    end
  end

  assign alu_f     = f_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rv_q;
  assign rsp_id    = id_q;
  assign rsp_y     = ry_q;
  assign rsp_dz    = rdz_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with NREQ=2, SETTLE=2, paired with a
// behavioural ALU model driving alu_y from alu_f/alu_a/alu_b.
module tb_alu_share_ctrl;

  localparam int NREQ   = 2;
  localparam int SETTLE = 2;
  localparam int IDW    = 1;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [3:0]        alu_f;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [63:0]       alu_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [63:0]       rsp_y;
  logic              rsp_dz;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  alu_share_ctrl #(
    .NREQ   (NREQ),
    .SETTLE (SETTLE),
    .IDW    (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_f     (alu_f),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_dz    (rsp_dz),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external ALU model ----------------
  function automatic logic [63:0] alu_model(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    case (f)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea * eb;
      4'd3:    return (b == 32'd0) ? 64'd0 : (ea % eb);
      4'd4:    return (b == 32'd0) ? 64'd0 : (ea / eb);
      4'd5:    return ea + 64'd1;
      4'd6:    return ea - 64'd1;
      4'd7:    return ea & eb;
      4'd8:    return ea | eb;
      4'd9:    return ea ^ eb;
      4'd10:   return {32'd0, ~(a & b)};
      4'd11:   return {32'd0, ~(a | b)};
      4'd12:   return {32'd0, ~(a ^ b)};
      4'd13:   return ea >> 1;
      4'd14:   return ea << 1;
      default: return {32'd0, ~a};
    endcase
  endfunction

  assign alu_y = alu_model(alu_f, alu_a, alu_b);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for rsp_valid; a timeout counts as one failed comparison.
  task automatic wait_rsp(input int max_cyc);
    int cyc;
    cyc = 0;
    while (!rsp_valid && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
  endtask

  // Scoreboard: compare the response against the oldest expected result.
  task automatic check_rsp(input string tag, input logic [IDW-1:0] id);
    logic [63:0] e;
    check({tag, "_q_nonempty"}, {63'd0, exp_q.size() != 0}, 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD;
    check({tag, "_y"}, rsp_y, e);
    check({tag, "_id"}, {{(64-IDW){1'b0}}, rsp_id}, {{(64-IDW){1'b0}}, id});
    check({tag, "_dz"}, {63'd0, rsp_dz}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_y"}, rsp_y, 64'd0);
    check({tag, "_rsp_dz"}, {63'd0, rsp_dz}, 64'd0);
    check({tag, "_rsp_id"}, {63'd0, rsp_id}, 64'd0);
    check({tag, "_alu"}, {28'd0, alu_f, alu_a}, 64'd0);
    check({tag, "_alu_b"}, {32'd0, alu_b}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    apply_reset();

    // 1: single ADD from requester 0, latency SETTLE
    rsp_ready = 1'b1;
    set_req(0, 4'd0, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    check("t1_ready", {62'd0, req_ready}, 64'd1);
    tick();                               // edge k
    req_valid = 2'b00;
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_alu_in", {28'd0, alu_f, alu_a}, {28'd0, 4'd0, 32'd5});
    check("t1_alu_b", {32'd0, alu_b}, 64'd7);
    check("t1_no_rsp_k", {63'd0, rsp_valid}, 64'd0);
    tick();                               // k+1
    check("t1_no_rsp_k1", {63'd0, rsp_valid}, 64'd0);
    check("t1_alu_hold", {32'd0, alu_b}, 64'd7);
    tick();                               // k+2
    check("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    exp_q.push_back(64'd12);
    check_rsp("t1", 1'b0);
    tick();
    check("t1_release", {63'd0, rsp_valid}, 64'd0);
    check("t1_idle", {63'd0, busy}, 64'd0);

    // 2: both valid after reset -> requester 1 first
    apply_reset();
    rsp_ready = 1'b1;
    set_req(0, 4'd2, 32'd3, 32'd4);
    set_req(1, 4'd1, 32'd9, 32'd2);
    req_valid = 2'b11;
    #1;
    check("t2_first_grant", {62'd0, req_ready}, 64'd2);
    exp_q.push_back(64'd7);
    tick();
    req_valid = 2'b01;
    wait_rsp(5);
    check_rsp("t2a", 1'b1);
    tick();
    check("t2_second_grant", {62'd0, req_ready}, 64'd1);
    exp_q.push_back(64'd12);
    tick();
    req_valid = 2'b00;
    wait_rsp(5);
    check_rsp("t2b", 1'b0);
    tick();

    // 3: DIV by zero from requester 1 -> immediate dz response
    set_req(1, 4'd4, 32'd10, 32'd0);
    req_valid = 2'b10;
    #1;
    check("t3_ready", {62'd0, req_ready}, 64'd2);
    tick();
    req_valid = 2'b00;
    check("t3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t3_dz", {63'd0, rsp_dz}, 64'd1);
    check("t3_y", rsp_y, 64'd0);
    check("t3_id", {63'd0, rsp_id}, 64'd1);
    check("t3_alu_keep", {28'd0, alu_f, alu_a}, {28'd0, 4'd2, 32'd3});
    check("t3_alu_b_keep", {32'd0, alu_b}, 64'd4);
    tick();
    check("t3_idle", {63'd0, busy}, 64'd0);
    check("t3_release", {63'd0, rsp_valid}, 64'd0);

    // 4: MUL with back-pressure for 5 cycles
    rsp_ready = 1'b0;
    set_req(0, 4'd2, 32'hFFFF_FFFF, 32'd2);
    req_valid = 2'b01;
    #1;
    check("t4_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b11;                    // others keep asking; must not be granted
    set_req(1, 4'd0, 32'd1, 32'd1);
    tick();
    check("t4_exec_ready0", {62'd0, req_ready}, 64'd0);
    tick();
    check("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_y", rsp_y, 64'h1_FFFF_FFFE);
      check("t4_hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("t4_hold_ready0", {62'd0, req_ready}, 64'd0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    check("t4_still_valid", {63'd0, rsp_valid}, 64'd1);
    tick();
    check("t4_release", {63'd0, rsp_valid}, 64'd0);
    check("t4_idle", {63'd0, busy}, 64'd0);

    // 5: async reset while requester 1's op is in EXEC
    set_req(1, 4'd0, 32'd1, 32'd1);
    req_valid = 2'b10;
    #1;
    check("t5_ready", {62'd0, req_ready}, 64'd2);
    tick();
    req_valid = 2'b00;
    check("t5_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_no_stale_a", {63'd0, rsp_valid}, 64'd0);
    tick();
    check("t5_no_stale_b", {63'd0, rsp_valid}, 64'd0);
    check("t5_idle", {63'd0, busy}, 64'd0);

    // 6: both continuously valid -> strict alternation 1,0,1,0...
    set_req(0, 4'd0, 32'd20, 32'd22);
    set_req(1, 4'd1, 32'd50, 32'd9);
    req_valid = 2'b11;
    #1;
    for (int n = 0; n < 8; n++) begin
      int w;
      logic [IDW-1:0] eid;
      eid = (n % 2 == 0) ? 1'b1 : 1'b0;
      w = 0;
      while (req_ready == '0 && w < 10) begin
        tick();
        w++;
      end
      check("t6_grant", {62'd0, req_ready}, (n % 2 == 0) ? 64'd2 : 64'd1);
      exp_q.push_back((n % 2 == 0) ? 64'd41 : 64'd42);
      tick();
      wait_rsp(5);
      check_rsp("t6", eid);
      tick();
    end
    req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
